// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared constants for the UART receive frame controller.
// Contents:
//   SYNC_BYTE          - first byte of every command frame
//   ERR_*              - values reported on o_Err_Code
//   IDLE .. DRAIN      - 3-bit FSM state encoding
package uart_rx_frame_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_ST = 3'd1;
  localparam logic [2:0] LEN_ST  = 3'd2;
  localparam logic [2:0] DATA_ST = 3'd3;
  localparam logic [2:0] CSUM_ST = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;

endpackage

// File: rtl/uart_rx_frame_ctrl_timeout.sv
// Inter-byte timeout down-counter.
// Ports:
//   i_Clock, i_Reset - clock, synchronous active-high reset
//   i_Clear          - reload to CLKS-1 (wins over expiry in the same cycle)
//   i_Enable         - count down while high
//   o_Expire         - high for the one cycle the counter sits at zero while
//                      enabled and not being cleared
module uart_frame_timeout #(
  parameter int unsigned CLKS = 3480
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam int unsigned CW = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLKS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else if (i_Clear) begin
      cnt_q <= LOAD;
    end else if (i_Enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  // Cycle count from the clearing strobe to expiry is CLKS.
  assign o_Expire = i_Enable && !i_Clear && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver.
// Parses SYNC, ADDR, LEN, payload, checksum; buffers the payload and, only
// once the XOR checksum matches, drains it as LEN consecutive writes to
// auto-incrementing addresses. Aborts on bad length, bad checksum or
// inter-byte timeout.
// Ports:
//   i_Clock, i_Reset         - clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte       - one-cycle byte strobe and byte from receiver
//   o_Wr_En/Addr/Data        - register write port
//   o_Frame_Done             - one-cycle pulse after the last write
//   o_Frame_Err, o_Err_Code  - abort pulse and sticky last error code
//   o_Busy                   - FSM not in IDLE
// Handshake: i_Rx_DV is a pure strobe with no back-pressure; a strobe
// arriving while draining is dropped.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 87,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    base_q;
  logic [7:0]    csum_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    pay_mem [MAX_LEN];

  logic tmo_enable, tmo_expire;
  logic len_bad, data_last, drain_last, csum_ok;

  assign len_bad    = (i_Rx_Byte == 8'd0) || ({24'd0, i_Rx_Byte} > MAX_LEN);
  assign data_last  = ((idx_q + IDX_ONE) == len_q);
  assign drain_last = (idx_q == len_q);
  assign csum_ok    = (i_Rx_Byte == csum_q);
  assign tmo_enable = (state_q == ADDR_ST) || (state_q == LEN_ST) ||
                      (state_q == DATA_ST) || (state_q == CSUM_ST);

  // Every strobe restarts the timeout; entry to ADDR_ST is itself a strobe.
  uart_frame_timeout #(.CLKS(TIMEOUT_CLKS)) u_timeout (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Rx_DV),
    .i_Enable (tmo_enable),
    .o_Expire (tmo_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = ADDR_ST;
      ADDR_ST: if (i_Rx_DV) state_d = LEN_ST;
               else if (tmo_expire) state_d = IDLE;
      LEN_ST:  if (i_Rx_DV) state_d = len_bad ? IDLE : DATA_ST;
               else if (tmo_expire) state_d = IDLE;
      DATA_ST: if (i_Rx_DV) state_d = data_last ? CSUM_ST : DATA_ST;
               else if (tmo_expire) state_d = IDLE;
      CSUM_ST: if (i_Rx_DV) state_d = csum_ok ? DRAIN : IDLE;
               else if (tmo_expire) state_d = IDLE;
      DRAIN:   if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload storage has no reset; contents are only read after a full frame.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && (state_q == DATA_ST) && i_Rx_DV) begin
      pay_mem[idx_q[AW-1:0]] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      base_q       <= 8'd0;
      csum_q       <= 8'd0;
      len_q        <= '0;
      idx_q        <= '0;
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= 8'd0;
      o_Wr_Data    <= 8'd0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= ERR_NONE;
      o_Busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_Busy       <= (state_d != IDLE);
      o_Wr_En      <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Frame_Err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) csum_q <= 8'd0;
        end
        ADDR_ST: begin
          if (i_Rx_DV) begin
            base_q <= i_Rx_Byte;
            csum_q <= csum_q ^ i_Rx_Byte;
          end else if (tmo_expire) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
          end
        end
        LEN_ST: begin
          if (i_Rx_DV) begin
            if (len_bad) begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_LEN;
            end else begin
              len_q  <= i_Rx_Byte[IW-1:0];
              csum_q <= csum_q ^ i_Rx_Byte;
              idx_q  <= '0;
            end
          end else if (tmo_expire) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
          end
        end
        DATA_ST: begin
          if (i_Rx_DV) begin
            csum_q <= csum_q ^ i_Rx_Byte;
            idx_q  <= idx_q + IDX_ONE;
          end else if (tmo_expire) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
          end
        end
        CSUM_ST: begin
          if (i_Rx_DV) begin
            if (csum_ok) begin
              // First write goes out the cycle after the checksum strobe,
              // so entry 0 is issued here and the drain index starts at 1.
              o_Wr_En   <= 1'b1;
              o_Wr_Addr <= base_q;
              o_Wr_Data <= pay_mem[0];
              idx_q     <= IDX_ONE;
            end else begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_CSUM;
            end
          end else if (tmo_expire) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
          end
        end
        DRAIN: begin
          if (drain_last) begin
            o_Frame_Done <= 1'b1;
          end else begin
            o_Wr_En   <= 1'b1;
            o_Wr_Addr <= o_Wr_Addr + 8'd1;  // wraps 0xFF -> 0x00
            o_Wr_Data <= pay_mem[idx_q[AW-1:0]];
            idx_q     <= idx_q + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame controller that sits directly behind the UART receiver.
- Consumes the receiver's one-cycle byte-valid strobe and byte. Parses framed write commands (SYNC, ADDR, LEN, payload, checksum) and buffers the payload.
- Issues auto-incrementing register writes only after the checksum verifies.
- Aborts on a bad length, a checksum mismatch or an inter-byte timeout, and reports the error.

Parameters:
- CLKS_PER_BIT, 87, clocks per UART bit; same value as the receiver instance.
- MAX_LEN, 16, maximum payload bytes per frame (1..255); sets the buffer depth.
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times; TIMEOUT_CLKS = CLKS_PER_BIT*10*TIMEOUT_BYTES.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  reset
- i_Rx_DV  in  1  byte-valid strobe from receiver, one cycle wide
- i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1
- o_Wr_En  out  1  write strobe
- o_Wr_Addr  out  8  write address
- o_Wr_Data  out  8  write data
- o_Frame_Done  out  1  one-cycle pulse, frame committed
- o_Frame_Err  out  1  one-cycle pulse, frame aborted
- o_Err_Code  out  2  last error: 0 none, 1 length, 2 checksum, 3 timeout
- o_Busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (i_Clock); reset (i_Reset) is synchronous and active-high.
- Reset: all outputs 0, state IDLE, running checksum 0, counters 0. Reset mid-frame or mid-drain discards the frame; no further writes are issued.
- Running checksum is the XOR of the ADDR byte, the LEN byte and all payload bytes. The frame is valid when the received checksum byte equals the running XOR.
- IDLE:
  - i_Rx_DV with byte 0xA5 -> ADDR_ST; checksum cleared.
  - Any other byte is ignored; no error is flagged.
- ADDR_ST: on i_Rx_DV, latch base address, fold into checksum -> LEN_ST.
- LEN_ST: on i_Rx_DV:
  - LEN=0 or LEN>MAX_LEN -> error 1, back to IDLE.
  - Otherwise latch LEN, fold into checksum, clear write index -> DATA_ST.
- DATA_ST: on i_Rx_DV, store byte at buf[idx], fold into checksum, idx++. After the LEN-th byte -> CSUM_ST.
- CSUM_ST: on i_Rx_DV:
  - Mismatch -> error 2, back to IDLE; the buffer is not written out.
  - Match -> DRAIN, idx=0.
- DRAIN:
  - o_Wr_En=1 for exactly LEN consecutive cycles, starting the cycle after the checksum strobe.
  - o_Wr_Addr = (base+idx) mod 256; wraps 0xFF->0x00.
  - o_Wr_Data = buf[idx].
  - o_Frame_Done pulses in the cycle after the last write, then IDLE.
  - i_Rx_DV during DRAIN is dropped; it cannot occur when CLKS_PER_BIT*10 > MAX_LEN+2, and the bench asserts that condition.
- Timeout:
  - Counter clears on every accepted strobe and on entry to ADDR_ST.
  - Counts in ADDR_ST, LEN_ST, DATA_ST and CSUM_ST.
  - Reaching TIMEOUT_CLKS-1 without a strobe -> error 3, back to IDLE.
  - A strobe in the same cycle as expiry: the strobe wins and the counter clears.
- Errors:
  - o_Frame_Err is a one-cycle pulse in the cycle the error state transition registers.
  - o_Err_Code updates in that same cycle and holds until the next error or reset.
  - A successful frame does not clear o_Err_Code.
- All outputs are registered. Payload buffer is MAX_LEN x 8 bits, written only in DATA_ST and read only in DRAIN.

Decomposition:
- Shared package holds:
  - SYNC_BYTE = 8'hA5
  - error code constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT
  - the 3-bit state encoding IDLE, ADDR_ST, LEN_ST, DATA_ST, CSUM_ST, DRAIN
- One sub-module, uart_frame_timeout: parameterised down-counter with clear and enable inputs and a one-cycle expire output. It is reused later for the TX side.

Test Plan:
- Good frame A5 10 03 11 22 33 csum=0x13 -> three consecutive writes (0x10,0x11),(0x11,0x22),(0x12,0x33); o_Frame_Done one cycle after the last write; o_Frame_Err never asserted.
- Same frame with csum=0x14 -> no o_Wr_En; o_Frame_Err pulse; o_Err_Code=2; o_Busy low afterwards.
- A5 00 00 (LEN=0) and A5 00 11 (LEN=17 with MAX_LEN=16) -> o_Err_Code=1, no writes. Leading garbage 00 FF 5A before A5 is ignored.
- A5 20 02 AA, then no stimulus for TIMEOUT_CLKS cycles -> o_Err_Code=3 at expiry. A following complete frame is accepted normally.
- Base address 0xFE, LEN=3 -> write addresses 0xFE, 0xFF, 0x00.
- Assert i_Reset in DATA_ST and again in the second DRAIN cycle -> outputs 0 the next cycle, no further o_Wr_En, and the next good frame succeeds.
